// File: rtl/trig_time_gen_if.sv
// Trigger time output stream: queue head plus ready/valid handshake.
interface trig_time_gen_if;
    logic [15:0] trig_time_o;
    logic [15:0] trig_num_o;
    logic        trig_time_valid_o;
    logic        trig_time_ready_i;

    modport master (
        output trig_time_o,
        output trig_num_o,
        output trig_time_valid_o,
        input  trig_time_ready_i
    );

    modport slave (
        input  trig_time_o,
        input  trig_num_o,
        input  trig_time_valid_o,
        output trig_time_ready_i
    );
endinterface

// File: rtl/trig_time_gen.sv
// Trigger timestamp generator with holdoff, FWFT output queue and run control.
// Optional drop counter enabled by defining TRIG_TIME_GEN_DROP_CNT_EN.
module trig_time_gen #(
    parameter int unsigned HOLDOFF = 16,
    parameter int unsigned QDEPTH  = 4
) (
    input  logic              aclk_i,
    input  logic              aclk_rst_i,
    input  logic              run_start_i,
    input  logic              run_stop_i,
    input  logic              trig_i,
    input  logic [11:0]       trig_offset_i,
    trig_time_gen_if.master   out_if,
    output logic [15:0]       drop_count_o,
    output logic              running_o
);
    localparam int AW = $clog2(QDEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
    localparam logic [1:0] S_FLUSH = 2'd3;

    logic [14:0]   tcnt_q;
    logic [1:0]    state_q, state_d;
    logic [15:0]   hcnt_q, hcnt_d;
    logic [15:0]   num_q, num_d;
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q, cnt_d;
    logic [14:0]   tmem_q [QDEPTH];
    logic [15:0]   nmem_q [QDEPTH];

    logic full, empty, start, stop, acc, deq, flush;

    assign full  = cnt_q == (AW+1)'(QDEPTH);
    assign empty = cnt_q == '0;
    assign start = run_start_i && (state_q == S_IDLE);
    assign stop  = run_stop_i && ((state_q == S_RUN) || (state_q == S_HOLD));
    assign acc   = trig_i && !run_stop_i && (state_q == S_RUN) && !full;
    assign flush = stop || (state_q == S_FLUSH);
    assign deq   = !empty && out_if.trig_time_ready_i;

    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (run_start_i) state_d = S_RUN;
            end
            S_RUN: begin
                if (run_stop_i) begin
                    state_d = S_FLUSH;
                end else if (acc) begin
                    state_d = S_HOLD;
                    hcnt_d  = 16'(HOLDOFF - 1);
                end
            end
            S_HOLD: begin
                if (run_stop_i) state_d = S_FLUSH;
                else if (hcnt_q == '0) state_d = S_RUN;
                else hcnt_d = hcnt_q - 16'd1;
            end
            S_FLUSH: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        num_d = num_q;
        if (start) num_d = '0;
        else if (acc) num_d = num_q + 16'd1;
    end

    // Full is judged before the dequeue, so a pop never makes room for a same-cycle push.
    always_comb begin
        cnt_d = cnt_q;
        if (flush) cnt_d = '0;
        else if (acc && !deq) cnt_d = cnt_q + 1'b1;
        else if (!acc && deq) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge aclk_i) begin
        if (aclk_rst_i) begin
            tcnt_q  <= '0;
            state_q <= S_IDLE;
            hcnt_q  <= '0;
            num_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
        end else begin
            tcnt_q  <= tcnt_q + 15'd1;
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            num_q   <= num_d;
            cnt_q   <= cnt_d;
            if (flush) begin
                wr_q <= '0;
                rd_q <= '0;
            end else begin
                if (acc) wr_q <= wr_q + 1'b1;
                if (deq) rd_q <= rd_q + 1'b1;
            end
        end
    end

    always_ff @(posedge aclk_i) begin
        if (acc) begin
            tmem_q[wr_q] <= tcnt_q - 15'(trig_offset_i);
            nmem_q[wr_q] <= num_q;
        end
    end

`ifdef TRIG_TIME_GEN_DROP_CNT_EN
    logic        drop;
    logic [15:0] drop_q;

    assign drop = trig_i && !run_stop_i
                  && (((state_q == S_RUN) && full) || (state_q == S_HOLD));

    always_ff @(posedge aclk_i) begin
        if (aclk_rst_i) drop_q <= '0;
        else if (start) drop_q <= '0;
        else if (drop && (drop_q != 16'hFFFF)) drop_q <= drop_q + 16'd1;
    end

    assign drop_count_o = drop_q;
`else
    assign drop_count_o = '0;
`endif

    assign out_if.trig_time_valid_o = !empty;
    assign out_if.trig_time_o = empty ? 16'h0 : {1'b0, tmem_q[rd_q]};
    assign out_if.trig_num_o  = empty ? 16'h0 : nmem_q[rd_q];
    assign running_o = (state_q == S_RUN) || (state_q == S_HOLD);
endmodule

// File: tb/tb_trig_time_gen.sv
// Directed vector table plus hand-written sequences for trig_time_gen.
module tb_trig_time_gen;
    logic        clk = 1'b0;
    logic        rst, start, stop, trig;
    logic [11:0] off;
    logic [15:0] drop;
    logic        running;
    logic [14:0] tc;
    int          nvec = 0;
    int          nbad = 0;

`ifdef TRIG_TIME_GEN_DROP_CNT_EN
    localparam bit DE = 1'b1;
`else
    localparam bit DE = 1'b0;
`endif

    trig_time_gen_if tt ();

    trig_time_gen #(.HOLDOFF(16), .QDEPTH(4)) dut (
        .aclk_i        (clk),
        .aclk_rst_i    (rst),
        .run_start_i   (start),
        .run_stop_i    (stop),
        .trig_i        (trig),
        .trig_offset_i (off),
        .out_if        (tt),
        .drop_count_o  (drop),
        .running_o     (running)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    typedef struct {
        bit          r;
        logic [14:0] at;
        bit          st, sp, tg;
        logic [11:0] off;
        bit          rd;
        bit          ev;
        logic [15:0] et, en;
        bit          er;
        logic [15:0] ed;
    } vec_t;

    function automatic int d(input int n);
        return DE ? n : 0;
    endfunction

    function automatic vec_t mk(input bit r, input int at, input bit st,
                                input bit sp, input bit tg, input int o,
                                input bit rd, input bit ev, input int et,
                                input int en, input bit er, input int ed);
        vec_t v;
        v.r = r; v.at = 15'(at); v.st = st; v.sp = sp; v.tg = tg;
        v.off = 12'(o); v.rd = rd; v.ev = ev; v.et = 16'(et);
        v.en = 16'(en); v.er = er; v.ed = 16'(ed);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] a,
                       input logic [31:0] e);
        nvec++;
        if (a !== e) begin
            nbad++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rst) tc = '0;
        else tc = tc + 15'd1;
    endtask

    task automatic wait_to(input logic [14:0] c);
        int g = 0;
        while (tc != c && g < 40000) begin
            tick();
            g++;
        end
        chk("wait_to", 32'(tc), 32'(c));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic pulse_trig(input logic [14:0] c, input int o);
        wait_to(c);
        trig = 1'b1;
        off = 12'(o);
        tick();
        trig = 1'b0;
    endtask

    task automatic chk_out(input string nm, input bit v, input int t,
                           input int n);
        chk({nm, ".valid"}, 32'(tt.trig_time_valid_o), 32'(v));
        chk({nm, ".time"},  32'(tt.trig_time_o), 32'(t));
        chk({nm, ".num"},   32'(tt.trig_num_o), 32'(n));
    endtask

    vec_t tbl [12];

    initial begin
        int got;
        int gn [3];
        int gt [3];
        logic [14:0] c0;

        rst = 1'b1; start = 1'b0; stop = 1'b0; trig = 1'b0; off = '0;
        tt.trig_time_ready_i = 1'b0;
        tc = '0;

        //          r  at      st sp tg off    rd ev et       en er ed
        tbl[0]  = mk(1, 0,      0, 0, 0, 0,     0, 0, 0,       0, 0, 0);
        tbl[1]  = mk(0, 'h100,  1, 0, 0, 0,     0, 0, 0,       0, 1, 0);
        tbl[2]  = mk(0, 'h200,  0, 0, 1, 'h40,  0, 1, 'h1C0,   0, 1, 0);
        tbl[3]  = mk(0, 'h203,  0, 0, 0, 0,     1, 0, 0,       0, 1, 0);
        tbl[4]  = mk(0, 'h300,  0, 1, 0, 0,     0, 0, 0,       0, 0, 0);
        tbl[5]  = mk(1, 0,      1, 0, 1, 0,     0, 0, 0,       0, 0, 0);
        tbl[6]  = mk(0, 'h002,  1, 0, 0, 0,     0, 0, 0,       0, 1, 0);
        tbl[7]  = mk(0, 'h010,  0, 0, 1, 'h20,  0, 1, 'h7FF0,  0, 1, 0);
        tbl[8]  = mk(0, 'h020,  0, 0, 1, 0,     0, 1, 'h7FF0,  0, 1, d(1));
        tbl[9]  = mk(0, 'h021,  0, 0, 1, 1,     0, 1, 'h7FF0,  0, 1, d(1));
        tbl[10] = mk(0, 'h022,  0, 0, 0, 0,     1, 1, 'h0020,  1, 1, d(1));
        tbl[11] = mk(0, 'h023,  0, 0, 0, 0,     1, 0, 0,       0, 1, d(1));

        for (int i = 0; i < 12; i++) begin
            string nm;
            nm = $sformatf("v%0d", i);
            if (!tbl[i].r) wait_to(tbl[i].at);
            rst = tbl[i].r; start = tbl[i].st; stop = tbl[i].sp;
            trig = tbl[i].tg; off = tbl[i].off;
            tt.trig_time_ready_i = tbl[i].rd;
            tick();
            rst = 1'b0; start = 1'b0; stop = 1'b0; trig = 1'b0;
            chk_out(nm, tbl[i].ev, int'(tbl[i].et), int'(tbl[i].en));
            chk({nm, ".running"}, 32'(running), 32'(tbl[i].er));
            chk({nm, ".drop"}, 32'(drop), 32'(tbl[i].ed));
        end

        // Continuous triggering against a 16-cycle holdoff.
        tt.trig_time_ready_i = 1'b0;
        do_reset();
        wait_to(15'd5);
        start = 1'b1;
        tick();
        start = 1'b0;
        tt.trig_time_ready_i = 1'b1;
        trig = 1'b1;
        off = '0;
        c0 = tc;
        got = 0;
        for (int i = 0; i < 43; i++) begin
            if (i == 40) trig = 1'b0;
            if (tt.trig_time_valid_o) begin
                if (got < 3) begin
                    gn[got] = int'(tt.trig_num_o);
                    gt[got] = int'(tt.trig_time_o);
                end
                got++;
            end
            tick();
        end
        chk("hold.count", 32'(got), 32'd3);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("hold.num%0d", k), 32'(gn[k]), 32'(k));
            chk($sformatf("hold.time%0d", k), 32'(gt[k]),
                32'(c0 + 15'(17 * k)));
        end
        chk("hold.drop", 32'(drop), 32'(d(37)));
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("hold.stop_running", 32'(running), 32'd0);

        // Queue fills, head held stable, drops counted, then drained.
        tt.trig_time_ready_i = 1'b0;
        do_reset();
        wait_to(15'd3);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            pulse_trig(15'(16'h40 + 20 * k), 5);
            chk_out($sformatf("full.head%0d", k), 1'b1, 'h3B, 0);
        end
        chk("full.drop", 32'(drop), 32'(d(2)));
        wait_to(15'h40 + 15'd120);
        trig = 1'b1;
        tt.trig_time_ready_i = 1'b1;
        tick();
        trig = 1'b0;
        chk_out("full.popdrop", 1'b1, 'h4F, 1);
        chk("full.drop2", 32'(drop), 32'(d(3)));
        for (int k = 1; k < 4; k++) begin
            chk_out($sformatf("full.drain%0d", k), 1'b1, 'h40 + 20 * k - 5, k);
            tick();
        end
        chk_out("full.empty", 1'b0, 0, 0);

        // Stop with a concurrent trigger flushes the queue.
        tt.trig_time_ready_i = 1'b0;
        do_reset();
        wait_to(15'd3);
        start = 1'b1;
        tick();
        start = 1'b0;
        pulse_trig(15'h10, 0);
        pulse_trig(15'h12, 0);
        pulse_trig(15'h30, 0);
        chk("stop.pre_drop", 32'(drop), 32'(d(1)));
        wait_to(15'h38);
        stop = 1'b1;
        trig = 1'b1;
        tick();
        stop = 1'b0;
        trig = 1'b0;
        chk_out("stop.flushed", 1'b0, 0, 0);
        chk("stop.running", 32'(running), 32'd0);
        chk("stop.drop", 32'(drop), 32'(d(1)));
        tick();
        trig = 1'b1;
        tick();
        trig = 1'b0;
        chk_out("stop.idle_trig", 1'b0, 0, 0);
        chk("stop.idle_drop", 32'(drop), 32'(d(1)));
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("stop.restart_drop", 32'(drop), 32'd0);
        c0 = tc;
        trig = 1'b1;
        off = '0;
        tick();
        trig = 1'b0;
        chk_out("stop.renum", 1'b1, int'(c0), 0);

        // Reset in the middle of holdoff with three entries queued.
        do_reset();
        wait_to(15'd3);
        start = 1'b1;
        tick();
        start = 1'b0;
        pulse_trig(15'h10, 0);
        pulse_trig(15'h30, 0);
        pulse_trig(15'h50, 0);
        pulse_trig(15'h52, 0);
        chk_out("rst.pre", 1'b1, 'h10, 0);
        rst = 1'b1;
        trig = 1'b1;
        tt.trig_time_ready_i = 1'b1;
        tick();
        rst = 1'b0;
        chk_out("rst.cleared", 1'b0, 0, 0);
        chk("rst.running", 32'(running), 32'd0);
        chk("rst.drop", 32'(drop), 32'd0);
        tick();
        tick();
        trig = 1'b0;
        chk_out("rst.no_start", 1'b0, 0, 0);
        chk("rst.no_start_drop", 32'(drop), 32'd0);
        tt.trig_time_ready_i = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        c0 = tc;
        trig = 1'b1;
        tick();
        trig = 1'b0;
        chk_out("rst.after_start", 1'b1, int'(c0), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule

// File: doc/trig_time_gen.md
TRIG_TIME_GEN -- requirements
Module: trig_time_gen

Interface
REQ-001 SHALL have parameter HOLDOFF, default 16, meaning aclk cycles after an accepted trigger during which new triggers are rejected (range 1..65535).
REQ-002 SHALL have parameter QDEPTH, default 4, meaning output queue depth in entries (power of two, 2..16).
REQ-003 aclk_i  input  1  sole clock; all logic on its rising edge.
REQ-004 aclk_rst_i  input  1  reset, synchronous, active-high.
REQ-005 run_start_i  input  1  single-cycle pulse, begin run.
REQ-006 run_stop_i  input  1  single-cycle pulse, end run.
REQ-007 trig_i  input  1  single-cycle trigger request.
REQ-008 trig_offset_i  input  12  lookback in aclk cycles, sampled with trig_i.
REQ-009 trig_time_o  output  16  queue head: {1'b0, 15-bit buffer time}.
REQ-010 trig_num_o  output  16  event number paired with trig_time_o.
REQ-011 trig_time_valid_o  output  1  queue head valid.
REQ-012 trig_time_ready_i  input  1  downstream accept.
REQ-013 drop_count_o  output  16  rejected-trigger count.
REQ-014 running_o  output  1  high in RUN or HOLDOFF.

Function
REQ-015 SHALL hold a 15-bit time counter incrementing every cycle, unconditionally, wrapping 0x7FFF->0x0000.
REQ-016 SHALL implement an FSM with states IDLE, RUN, HOLDOFF, FLUSH.
REQ-017 IDLE->RUN on run_start_i; run_start_i also clears trig_num and drop count; run_start_i outside IDLE is ignored.
REQ-018 Trigger accepted only when state is RUN, trig_i=1, run_stop_i=0, and queue not full.
REQ-019 On accept: enqueue time=(C - trig_offset_i) mod 2^15, C being the counter value in the same cycle; enqueue trig_num; then increment trig_num (wraps 0xFFFF->0); RUN->HOLDOFF.
REQ-020 HOLDOFF lasts exactly HOLDOFF cycles after the accept cycle, then ->RUN; a trigger on the first RUN cycle is accepted.
REQ-021 trig_i=1 when in RUN with queue full, or in HOLDOFF, SHALL increment drop count, saturating at 0xFFFF; trig_i in IDLE/FLUSH is ignored and not counted.
REQ-022 run_stop_i in RUN or HOLDOFF ->FLUSH; concurrent trig_i is neither accepted nor counted.
REQ-023 FLUSH empties the queue in one cycle (valid low next cycle) then ->IDLE; trig_num and drop count retained.
REQ-024 Queue is FIFO, first-word-fall-through: entry accepted at cycle N appears at output at N+1 if queue was empty.
REQ-025 trig_time_valid_o, once high, SHALL hold with stable trig_time_o/trig_num_o until a cycle with trig_time_ready_i=1.
REQ-026 Simultaneous enqueue and dequeue SHALL preserve occupancy; full means QDEPTH entries occupied, a dequeue in the same cycle does not free space for an enqueue.
REQ-027 trig_time_o[15] SHALL always be 0.

Reset
REQ-028 aclk_rst_i SHALL force: state IDLE, time counter 0, queue empty, trig_time_valid_o=0, trig_time_o=0, trig_num_o=0, drop_count_o=0, running_o=0, trig_num=0.
REQ-029 Reset asserted mid-run SHALL discard all queued entries with no output handshake completing on that cycle.
REQ-030 Reset dominates run_start_i, run_stop_i, trig_i in the same cycle.

Configuration
REQ-031 Macro TRIG_TIME_GEN_DROP_CNT_EN: defined -> drop counter implemented per REQ-021; undefined -> no counter logic, drop_count_o tied to 0, rejection behaviour otherwise unchanged.

Verification
REQ-032 Reset, run_start_i at counter=0x0100, trig_i with offset 0x040 at counter=0x0200 -> one output trig_time_o=0x01C0, trig_num_o=0, valid next cycle.
REQ-033 Wrap: trig_i at counter=0x0010, offset 0x020 -> trig_time_o=0x7FF0, bit 15 = 0.
REQ-034 HOLDOFF=16, trig_i every cycle for 40 cycles, ready=1 -> accepts at cycles 0, 17, 34; 3 outputs, trig_num 0,1,2; drop_count_o=37 (0 with macro undefined).
REQ-035 QDEPTH=4, ready=0, triggers spaced 20 cycles, 6 triggers -> 4 entries queued, valid held stable, drop_count_o=2; then ready=1 -> 4 outputs in order, trig_num 0..3.
REQ-036 Two entries queued, run_stop_i with trig_i same cycle -> valid low one cycle later, no drop increment, IDLE after FLUSH; next run_start_i resets trig_num_o to 0.
REQ-037 aclk_rst_i mid-HOLDOFF with 3 entries queued -> all outputs zero next cycle, state IDLE, run_start_i required before any trigger is accepted.
